// File: rtl/memory_256x16.sv
// -----------------------------------------------------------------------------
// memory_256x16
//   Single-port synchronous RAM, DEPTH x DATA_WIDTH, with a registered read
//   port and write-first behaviour (a write also loads DATA_OUT with DATA_IN).
//
// Ports
//   CLK      in   1           clock, all state updates on the rising edge
//   EN       in   1           access enable; 0 = no access, DATA_OUT holds
//   RST      in   1           asynchronous active-high reset
//   WRITE    in   1           1 = write, 0 = read (qualified by EN)
//   DATA_IN  in   DATA_WIDTH  write data
//   ADDR     in   ADDR_WIDTH  word address
//   DATA_OUT out  DATA_WIDTH  registered read data
//
// Configuration
//   MEMORY_CLEAR_ON_RESET_EN  when defined, RST also clears every stored word
//                             to zero asynchronously; otherwise the array
//                             survives reset and only DATA_OUT is cleared.
// -----------------------------------------------------------------------------
module memory_256x16 #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  EN,
   input  logic                  RST,
   input  logic                  WRITE,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   output logic [DATA_WIDTH-1:0] DATA_OUT
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] dout_q;
   logic [DATA_WIDTH-1:0] dout_d;
   logic                  wr_en;

   assign wr_en = EN & WRITE;

`ifdef MEMORY_CLEAR_ON_RESET_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[ADDR] <= DATA_IN;
      end
   end
`else
   // Reset level is sampled at the edge so an access coinciding with reset
   // is cancelled, while the array contents are left untouched.
   always_ff @(posedge CLK) begin
      if (!RST && wr_en) begin
         mem_q[ADDR] <= DATA_IN;
      end
   end
`endif

   always_comb begin
      dout_d = dout_q;
      if (EN) begin
         dout_d = WRITE ? DATA_IN : mem_q[ADDR];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_memory_256x16.sv
module tb_memory_256x16;

   logic        CLK = 1'b0;
   logic        EN = 1'b0;
   logic        RST = 1'b0;
   logic        WRITE = 1'b0;
   logic [15:0] DATA_IN = '0;
   logic [7:0]  ADDR = '0;
   logic [15:0] DATA_OUT;

   int total = 0;
   int bad = 0;

   typedef struct {
      string       name;
      logic        en;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[13];

`ifdef MEMORY_CLEAR_ON_RESET_EN
   localparam logic [15:0] EXP_ADDR7_AFTER_RST = 16'd0;
   localparam logic [15:0] EXP_ADDR3_AFTER_RST = 16'd0;
`else
   localparam logic [15:0] EXP_ADDR7_AFTER_RST = 16'd80;
   localparam logic [15:0] EXP_ADDR3_AFTER_RST = 16'd40;
`endif

   memory_256x16 #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) dut (
      .CLK(CLK),
      .EN(EN),
      .RST(RST),
      .WRITE(WRITE),
      .DATA_IN(DATA_IN),
      .ADDR(ADDR),
      .DATA_OUT(DATA_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one access, let one rising edge happen, sample 1 time unit later.
   task automatic cyc(input logic en, input logic wr, input logic [7:0] addr,
                      input logic [15:0] din);
      EN = en;
      WRITE = wr;
      ADDR = addr;
      DATA_IN = din;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"en0_write_blocked", 1'b0, 1'b1, 8'd5,   16'hFFFF, 16'd2560};
      vecs[1]  = '{"read5_unchanged",   1'b1, 1'b0, 8'd5,   16'h0000, 16'd60};
      vecs[2]  = '{"en0_read_hold",     1'b0, 1'b0, 8'd9,   16'h1111, 16'd60};
      vecs[3]  = '{"wr255_ffff",        1'b1, 1'b1, 8'd255, 16'hFFFF, 16'hFFFF};
      vecs[4]  = '{"read0",             1'b1, 1'b0, 8'd0,   16'h0000, 16'd10};
      vecs[5]  = '{"read255_ffff",      1'b1, 1'b0, 8'd255, 16'h0000, 16'hFFFF};
      vecs[6]  = '{"wr255_0000",        1'b1, 1'b1, 8'd255, 16'h0000, 16'h0000};
      vecs[7]  = '{"read1",             1'b1, 1'b0, 8'd1,   16'hFFFF, 16'd20};
      vecs[8]  = '{"read255_0000",      1'b1, 1'b0, 8'd255, 16'hFFFF, 16'h0000};
      vecs[9]  = '{"wr255_restore",     1'b1, 1'b1, 8'd255, 16'd2560, 16'd2560};
      vecs[10] = '{"wr100_a5a5",        1'b1, 1'b1, 8'd100, 16'hA5A5, 16'hA5A5};
      vecs[11] = '{"read100_new",       1'b1, 1'b0, 8'd100, 16'h0000, 16'hA5A5};
      vecs[12] = '{"read101",           1'b1, 1'b0, 8'd101, 16'h0000, 16'd1020};

      // Asynchronous reset: DATA_OUT goes to 0 before any clock edge.
      #2 RST = 1'b1;
      #1 chk("reset_async", DATA_OUT, 16'h0000);
      // Enabled edges under reset do nothing.
      cyc(1'b1, 1'b0, 8'd0, 16'h0000);
      chk("reset_hold_read", DATA_OUT, 16'h0000);
      cyc(1'b1, 1'b1, 8'd0, 16'hBEEF);
      chk("reset_hold_write", DATA_OUT, 16'h0000);
      @(negedge CLK);
      RST = 1'b0;

      // Fill with write-first checks.
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1, 1'b1, 8'(i), 16'((i + 1) * 10));
         chk("fill", DATA_OUT, 16'((i + 1) * 10));
      end
      chk("fill_last", DATA_OUT, 16'd2560);

      // Readback.
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1, 1'b0, 8'(i), 16'h0000);
         chk("readback", DATA_OUT, 16'((i + 1) * 10));
      end

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
         chk(vecs[i].name, DATA_OUT, vecs[i].exp);
      end

      // Reset pulsed between edges, then read address 7.
      @(negedge CLK);
      EN = 1'b0;
      RST = 1'b1;
      #1 chk("rst_pulse_dout0", DATA_OUT, 16'h0000);
      RST = 1'b0;
      #1 chk("rst_pulse_still0", DATA_OUT, 16'h0000);
      cyc(1'b1, 1'b0, 8'd7, 16'h0000);
      chk("read7_after_rst", DATA_OUT, EXP_ADDR7_AFTER_RST);

      // Reset held across a write edge: write cancelled.
      @(negedge CLK);
      RST = 1'b1;
      cyc(1'b1, 1'b1, 8'd3, 16'h1234);
      chk("rst_vs_write_dout", DATA_OUT, 16'h0000);
      @(negedge CLK);
      RST = 1'b0;
      cyc(1'b1, 1'b0, 8'd3, 16'h0000);
      chk("read3_after_rst", DATA_OUT, EXP_ADDR3_AFTER_RST);

      // First enabled edge after release is a normal write, then read back.
      cyc(1'b1, 1'b1, 8'd3, 16'h5A5A);
      chk("post_rst_write", DATA_OUT, 16'h5A5A);
      cyc(1'b0, 1'b0, 8'd0, 16'h0000);
      chk("post_rst_hold", DATA_OUT, 16'h5A5A);
      cyc(1'b1, 1'b0, 8'd3, 16'h0000);
      chk("post_rst_read", DATA_OUT, 16'h5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
